screen_sequencer: RTL and testbench

- Top-level screen/mode controller for the VGA game.
- Derives a once-per-frame tick from the raster position, debounces the start key and runs the MENU/LAUNCH/PLAY/OVER state machine.
- Drives the enable and blink controls consumed by the text menu renderer and the game renderer, plus the reset and run strobes for game logic.
- All mode changes occur on the frame tick, at the start of vertical blank, so no frame is ever drawn half in one mode.

---
 rtl/screen_sequencer_pkg.sv | 21 ++
 rtl/screen_sequencer_key_debounce.sv | 44 ++++
 rtl/screen_sequencer.sv | 152 +++++++++++++++
 tb/tb_screen_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen/mode controller: state encoding and raster defaults.
// The SCREEN_PAUSE_EN build adds S_PAUSE behaviour; the encoding is identical in both builds.
package screen_pkg;

    typedef enum logic [2:0] {
        S_MENU   = 3'd0,
        S_LAUNCH = 3'd1,
        S_PLAY   = 3'd2,
        S_OVER   = 3'd3,
        S_PAUSE  = 3'd4
    } screen_state_t;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned V_VISIBLE_DEF = 480;

    // Any state other than MENU shows the game layer.
    function automatic logic game_layer_visible(input screen_state_t s);
        return s != S_MENU;
    endfunction

endpackage

// File: rtl/screen_sequencer_key_debounce.sv
// Frame-rate key debouncer: emits one press strobe after DEBOUNCE_FRAMES consecutive
// high samples; the key must be released before another press can be produced.
module key_debounce
    import screen_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sample_i,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_FRAMES);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter saturates at TARGET, so a held key strobes exactly once.
    always_comb begin
        cnt_d   = cnt_q;
        press_o = 1'b0;
        if (sample_i) begin
            if (key_i) begin
                if (cnt_q != TARGET) begin
                    cnt_d   = cnt_q + 1'b1;
                    press_o = (cnt_d == TARGET);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Screen/mode controller: frame tick, start-key debounce and MENU/LAUNCH/PLAY/OVER FSM.
// Define SCREEN_PAUSE_EN to enable the PAUSE state (press toggles PLAY <-> PAUSE).
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int unsigned H_VISIBLE        = H_VISIBLE_DEF,
    parameter int unsigned V_VISIBLE        = V_VISIBLE_DEF,
    parameter int unsigned BLINK_FRAMES     = 30,
    parameter int unsigned DEBOUNCE_FRAMES  = 2,
    parameter int unsigned OVER_HOLD_FRAMES = 180
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [9:0] hpos_i,
    input  logic [9:0] vpos_i,
    input  logic       start_key_i,
    input  logic       player_dead_i,
    output logic       frame_tick_o,
    output logic [2:0] state_o,
    output logic       menu_en_o,
    output logic       game_en_o,
    output logic       game_run_o,
    output logic       game_reset_o,
    output logic       blink_o
);

    if (H_VISIBLE == 0 || H_VISIBLE > 1024 || V_VISIBLE >= 1024 ||
        BLINK_FRAMES == 0 || DEBOUNCE_FRAMES == 0 || OVER_HOLD_FRAMES == 0) begin : g_bad_cfg
        $error("screen_sequencer: invalid parameter set");
    end

    localparam logic [9:0] TICK_LINE = 10'(V_VISIBLE);
    localparam int unsigned HW = $clog2(OVER_HOLD_FRAMES + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(OVER_HOLD_FRAMES - 1);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    screen_state_t state_q, state_d;
    logic          match_q, tick_q;
    logic          raw_match;
    logic          dead_q, dead_d, dead_seen;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          menu_en_q, game_en_q, game_run_q, game_reset_q;
    logic          press;

    key_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_key_debounce (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .sample_i(tick_q),
        .key_i   (start_key_i),
        .press_o (press)
    );

    assign raw_match = (vpos_i == TICK_LINE) && (hpos_i == '0);
    // A death on the tick cycle itself counts for that tick rather than being dropped.
    assign dead_seen = dead_q | player_dead_i;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        dead_d  = dead_seen;
        if (tick_q) begin
            dead_d = 1'b0;
            case (state_q)
                S_MENU: begin
                    if (press) state_d = S_LAUNCH;
                end
                S_LAUNCH: state_d = S_PLAY;
                S_PLAY: begin
                    if (dead_seen) begin
                        state_d = S_OVER;
                        hold_d  = HOLD_LOAD;
                    end
`ifdef SCREEN_PAUSE_EN
                    else if (press) begin
                        state_d = S_PAUSE;
                    end
`endif
                end
`ifdef SCREEN_PAUSE_EN
                S_PAUSE: begin
                    if (press) state_d = S_PLAY;
                end
`endif
                S_OVER: begin
                    if (hold_q == '0) state_d = S_MENU;
                    else              hold_d  = hold_q - 1'b1;
                end
                default: state_d = S_MENU;
            endcase
        end
    end

    // Blink phase runs only while MENU persists; any entry or exit restarts it visible.
    always_comb begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
        if (state_q == S_MENU && state_d == S_MENU) begin
            blink_d     = blink_q;
            blink_cnt_d = blink_cnt_q;
            if (tick_q) begin
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = '0;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            match_q      <= 1'b0;
            tick_q       <= 1'b0;
            dead_q       <= 1'b0;
            state_q      <= S_MENU;
            hold_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
            menu_en_q    <= 1'b1;
            game_en_q    <= 1'b0;
            game_run_q   <= 1'b0;
            game_reset_q <= 1'b0;
        end else begin
            match_q      <= raw_match;
            tick_q       <= raw_match & ~match_q;
            dead_q       <= dead_d;
            state_q      <= state_d;
            hold_q       <= hold_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            menu_en_q    <= (state_d == S_MENU);
            game_en_q    <= game_layer_visible(state_d);
            game_run_q   <= (state_d == S_PLAY);
            game_reset_q <= (state_d == S_LAUNCH);
        end
    end

    assign frame_tick_o = tick_q;
    assign state_o      = state_q;
    assign menu_en_o    = menu_en_q;
    assign game_en_o    = game_en_q;
    assign game_run_o   = game_run_q;
    assign game_reset_o = game_reset_q;
    assign blink_o      = blink_q;

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer: frame-level vector table, directed corner sequences and
// a randomized phase, all checked every cycle against a frame-rule reference model.
module tb_screen_sequencer;

    localparam int unsigned HV         = 8;
    localparam int unsigned VV         = 4;
    localparam int unsigned H_TOTAL    = 10;
    localparam int unsigned V_TOTAL    = 6;
    localparam int unsigned PIX_CLKS   = 4;
    localparam int unsigned FRAME_CLKS = H_TOTAL * V_TOTAL * PIX_CLKS;
    localparam int unsigned DEB        = 2;
    localparam int unsigned OHF        = 3;
    localparam int unsigned BLF        = 2;

    localparam int M_MENU = 0, M_LAUNCH = 1, M_PLAY = 2, M_OVER = 3, M_PAUSE = 4;

    logic       clk, reset_i, start_key_i, player_dead_i;
    logic [9:0] hpos_i, vpos_i;
    logic       frame_tick_o, menu_en_o, game_en_o, game_run_o, game_reset_o, blink_o;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    screen_sequencer #(
        .H_VISIBLE       (HV),
        .V_VISIBLE       (VV),
        .BLINK_FRAMES    (BLF),
        .DEBOUNCE_FRAMES (DEB),
        .OVER_HOLD_FRAMES(OHF)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .hpos_i       (hpos_i),
        .vpos_i       (vpos_i),
        .start_key_i  (start_key_i),
        .player_dead_i(player_dead_i),
        .frame_tick_o (frame_tick_o),
        .state_o      (state_o),
        .menu_en_o    (menu_en_o),
        .game_en_o    (game_en_o),
        .game_run_o   (game_run_o),
        .game_reset_o (game_reset_o),
        .blink_o      (blink_o)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Raster with each pixel held PIX_CLKS clocks.
    initial begin
        int hx, vy, sub;
        hx = 0; vy = 0; sub = 0;
        hpos_i = '0; vpos_i = '0;
        forever begin
            @(negedge clk);
            if (sub == int'(PIX_CLKS) - 1) begin
                sub = 0;
                if (hx == int'(H_TOTAL) - 1) begin
                    hx = 0;
                    vy = (vy == int'(V_TOTAL) - 1) ? 0 : vy + 1;
                end else begin
                    hx++;
                end
            end else begin
                sub++;
            end
            hpos_i = 10'(hx);
            vpos_i = 10'(vy);
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode as an int, debounce as a run length of high samples,
    // blink derived from frames spent in MENU, OVER exit after OHF frames.
    bit          m_prev_raw = 0, m_tick = 0, m_dead = 0;
    int unsigned m_hi = 0, m_menu_ticks = 0, m_over_ticks = 0;
    int          m_mode = M_MENU;

    task automatic model_step();
        bit raw, died, press;
        raw = (vpos_i == 10'(VV)) && (hpos_i == 10'd0);
        if (reset_i) begin
            m_prev_raw = 0; m_tick = 0; m_dead = 0; m_hi = 0;
            m_menu_ticks = 0; m_over_ticks = 0; m_mode = M_MENU;
        end else begin
            m_dead = m_dead | player_dead_i;
            if (m_tick) begin
                press = 0;
                if (start_key_i) begin
                    m_hi++;
                    press = (m_hi == DEB);
                end else begin
                    m_hi = 0;
                end
                died = m_dead;
                m_dead = 0;
                case (m_mode)
                    M_MENU: begin
                        if (press) m_mode = M_LAUNCH;
                        else       m_menu_ticks++;
                    end
                    M_LAUNCH: m_mode = M_PLAY;
                    M_PLAY: begin
                        if (died) begin
                            m_mode = M_OVER;
                            m_over_ticks = 0;
                        end
`ifdef SCREEN_PAUSE_EN
                        else if (press) m_mode = M_PAUSE;
`endif
                    end
                    M_PAUSE: if (press) m_mode = M_PLAY;
                    default: begin
                        m_over_ticks++;
                        if (m_over_ticks == OHF) begin
                            m_mode = M_MENU;
                            m_menu_ticks = 0;
                        end
                    end
                endcase
            end
            m_tick = raw && !m_prev_raw;
            m_prev_raw = raw;
        end
    endtask

    function automatic logic [15:0] model_vec();
        bit blink;
        blink = (m_mode == M_MENU) ? (((m_menu_ticks / BLF) % 2) == 0) : 1'b1;
        return {7'd0, m_tick, 3'(m_mode), m_mode == M_MENU, m_mode != M_MENU,
                m_mode == M_PLAY, m_mode == M_LAUNCH, blink};
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en)
            check("model", {7'd0, frame_tick_o, state_o, menu_en_o, game_en_o,
                            game_run_o, game_reset_o, blink_o}, model_vec());
    end

    task automatic expect_outs(input string name, input logic [2:0] st, input bit menu,
                               input bit gen, input bit run, input bit grst, input bit blink);
        check(name, {8'd0, state_o, menu_en_o, game_en_o, game_run_o, game_reset_o, blink_o},
              {8'd0, st, menu, gen, run, grst, blink});
    endtask

    // Holds the key level for one frame (optional 1-cycle death mid-frame), waits for
    // the tick and stops one cycle later so registered outputs reflect that tick.
    task automatic run_frame(input bit key, input bit dead);
        bit seen;
        seen = 0;
        start_key_i = key;
        for (int c = 0; c < 2 * int'(FRAME_CLKS) && !seen; c++) begin
            player_dead_i = dead && (c == int'(FRAME_CLKS) / 2);
            @(negedge clk);
            if (frame_tick_o) seen = 1;
        end
        player_dead_i = 0;
        check("tick_seen", 16'(seen), 16'd1);
        @(negedge clk);
        check("tick_width", 16'(frame_tick_o), 16'd0);
    endtask

    typedef struct {
        bit         key;
        bit         dead;
        logic [2:0] st;
        bit         menu, gen, run, grst, blink;
    } vec_t;

    function automatic vec_t mk(input bit key, input bit dead, input logic [2:0] st, input bit menu,
                                input bit gen, input bit run, input bit grst, input bit blink);
        vec_t v;
        v.key = key; v.dead = dead; v.st = st; v.menu = menu;
        v.gen = gen; v.run = run; v.grst = grst; v.blink = blink;
        return v;
    endfunction

    task automatic pulse_reset();
        repeat (50) @(negedge clk);
        reset_i = 1;
        @(negedge clk);
        reset_i = 0;
        expect_outs("reset_mid", 3'd0, 1, 0, 0, 0, 1);
    endtask

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 1, 0, 0, 0, 1));  // one-tick glitch
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd1, 0, 1, 0, 1, 1));  // LAUNCH
        tbl.push_back(mk(1, 0, 3'd2, 0, 1, 1, 0, 1));  // PLAY after one frame
        tbl.push_back(mk(0, 0, 3'd2, 0, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 3'd3, 0, 1, 0, 0, 1));  // death mid-frame
        tbl.push_back(mk(1, 0, 3'd3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 3'd3, 0, 1, 0, 0, 1));  // press in OVER ignored
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 3'd1, 0, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 3'd2, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 3'd2, 0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 3'd3, 0, 1, 0, 0, 1));  // death beats press
        tbl.push_back(mk(0, 0, 3'd3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd3, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 3'd0, 1, 0, 0, 0, 1));

        reset_i = 1; start_key_i = 0; player_dead_i = 0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_tick", 16'(frame_tick_o), 16'd0);
        expect_outs("reset_state", 3'd0, 1, 0, 0, 0, 1);
        reset_i = 0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].key, tbl[i].dead);
            expect_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].menu, tbl[i].gen,
                        tbl[i].run, tbl[i].grst, tbl[i].blink);
        end

        run_frame(1, 0);
        run_frame(1, 0);
        expect_outs("relaunch", 3'd1, 0, 1, 0, 1, 1);
        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(1, 0);
`ifdef SCREEN_PAUSE_EN
        expect_outs("pause_enter", 3'd4, 0, 1, 0, 0, 1);
        run_frame(0, 1);
        expect_outs("pause_death_discarded", 3'd4, 0, 1, 0, 0, 1);
        run_frame(1, 0);
        run_frame(1, 0);
        expect_outs("pause_exit", 3'd2, 0, 1, 1, 0, 1);
        run_frame(0, 0);
        expect_outs("play_after_pause", 3'd2, 0, 1, 1, 0, 1);
`else
        expect_outs("play_press_ignored", 3'd2, 0, 1, 1, 0, 1);
        run_frame(0, 0);
        expect_outs("play_stays", 3'd2, 0, 1, 1, 0, 1);
`endif
        pulse_reset();
        run_frame(0, 0);
        expect_outs("after_reset_play", 3'd0, 1, 0, 0, 0, 1);

        run_frame(1, 0);
        run_frame(1, 0);
        expect_outs("launch_again", 3'd1, 0, 1, 0, 1, 1);
        pulse_reset();
        run_frame(0, 0);
        expect_outs("after_reset_launch", 3'd0, 1, 0, 0, 0, 1);

        start_key_i = 0;
        for (int c = 0; c < 15000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) start_key_i = ~start_key_i;
            player_dead_i = ($urandom_range(0, 299) == 0);
            reset_i       = ($urandom_range(0, 4999) == 0);
        end
        player_dead_i = 0;
        reset_i = 0;
        @(negedge clk);
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
